// File: rtl/vga_sync_gen.sv
// 640x480@60Hz VGA timing generator: pixel-rate divider, H/V counters and registered sync decode.
// Optional VGA_RGB_BLANK_EN adds rgb_in/rgb_out with blanking outside the visible window.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] HCount,
    output logic [9:0] VCount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel_tick,
`ifdef VGA_RGB_BLANK_EN
    input  logic [2:0] rgb_in,
    output logic [2:0] rgb_out,
`endif
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0]    V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]    HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]    HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]    VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]    VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d, v_q, v_d;
    logic          tick_q, tick_d;
    logic          hs_q, hs_d, vs_q, vs_d, vo_q, vo_d, fs_q, fs_d;
    // Set while in reset so the first cycle out of reset announces a new frame.
    logic          first_q;

    always_comb begin
        div_d = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
        tick_d = (div_d == DIV_MAX);
        h_d = h_q;
        v_d = v_q;
        if (tick_q) begin
            if (h_q == H_MAX) begin
                h_d = '0;
                v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        // Decode the next-state counters so the flags line up with HCount/VCount.
        hs_d = !((h_d >= HS_START) && (h_d <= HS_END));
        vs_d = !((v_d >= VS_START) && (v_d <= VS_END));
        vo_d = (h_d < H_VIS) && (v_d < V_VIS);
        fs_d = (h_d == '0) && (v_d == '0) && (tick_q || first_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            vo_q    <= 1'b0;
            fs_q    <= 1'b0;
            first_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            vo_q    <= vo_d;
            fs_q    <= fs_d;
            first_q <= 1'b0;
        end
    end

    assign HCount      = h_q;
    assign VCount      = v_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = vo_q;
    assign pixel_tick  = tick_q;
    assign frame_start = fs_q;

`ifdef VGA_RGB_BLANK_EN
    assign rgb_out = vo_q ? rgb_in : 3'b000;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a full-size 640x480 instance for line timing and a small
// instance (CLK_DIV=3, 16x12 total) for vertical, frame-wrap and mid-frame reset behaviour.
module tb_vga_sync_gen;
    typedef struct {
        int cyc;
        int sig;
        int exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst_f_n = 1'b0;
    logic rst_s_n = 1'b0;
    int   t = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    chk_t sb[$];

    logic [9:0] hc_f, vc_f, hc_s, vc_s;
    logic hs_f, vs_f, vo_f, pt_f, fs_f;
    logic hs_s, vs_s, vo_s, pt_s, fs_s;
    logic [2:0] rgb_in_f = 3'b101;
    logic [2:0] rgb_in_s = 3'b101;
    logic [2:0] rgb_out_f, rgb_out_s;

    string nm [16] = '{"f_hcount", "f_vcount", "f_hsync", "f_vsync", "f_video_on",
                       "f_pixel_tick", "f_frame_start", "s_hcount", "s_vcount", "s_hsync",
                       "s_vsync", "s_video_on", "s_pixel_tick", "s_frame_start",
                       "f_rgb_out", "s_rgb_out"};

    vga_sync_gen u_full (
        .clk(clk), .rst_n(rst_f_n), .HCount(hc_f), .VCount(vc_f), .hsync(hs_f), .vsync(vs_f),
        .video_on(vo_f), .pixel_tick(pt_f),
`ifdef VGA_RGB_BLANK_EN
        .rgb_in(rgb_in_f), .rgb_out(rgb_out_f),
`endif
        .frame_start(fs_f)
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u_small (
        .clk(clk), .rst_n(rst_s_n), .HCount(hc_s), .VCount(vc_s), .hsync(hs_s), .vsync(vs_s),
        .video_on(vo_s), .pixel_tick(pt_s),
`ifdef VGA_RGB_BLANK_EN
        .rgb_in(rgb_in_s), .rgb_out(rgb_out_s),
`endif
        .frame_start(fs_s)
    );

`ifndef VGA_RGB_BLANK_EN
    assign rgb_out_f = 3'b000;
    assign rgb_out_s = 3'b000;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) t <= t + 1;

    function automatic int rd(int s);
        case (s)
            0:  return int'(hc_f);
            1:  return int'(vc_f);
            2:  return int'(hs_f);
            3:  return int'(vs_f);
            4:  return int'(vo_f);
            5:  return int'(pt_f);
            6:  return int'(fs_f);
            7:  return int'(hc_s);
            8:  return int'(vc_s);
            9:  return int'(hs_s);
            10: return int'(vs_s);
            11: return int'(vo_s);
            12: return int'(pt_s);
            13: return int'(fs_s);
            14: return int'(rgb_out_f);
            default: return int'(rgb_out_s);
        endcase
    endfunction

    task automatic push(input int c, input int s, input int e);
        chk_t x;
        x.cyc = c;
        x.sig = s;
        x.exp = e;
        sb.push_back(x);
    endtask

    // Reset values: H=0, V=0, hsync=1, vsync=1, video_on=0, pixel_tick=0, frame_start=0.
    task automatic push_rst(input int c, input int b);
        push(c, b + 0, 0); push(c, b + 1, 0); push(c, b + 2, 1); push(c, b + 3, 1);
        push(c, b + 4, 0); push(c, b + 5, 0); push(c, b + 6, 0);
    endtask

    // Monitor: every cycle, compare any scoreboard entries due in this cycle.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == t) begin
                n_checks++;
                if (rd(sb[i].sig) != sb[i].exp) begin
                    n_errors++;
                    $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                             nm[sb[i].sig], t, rd(sb[i].sig), sb[i].exp);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        // Both instances: reset edges t=1..3, first released edge t=4 (n = t-3).
        for (int c = 1; c <= 3; c++) begin
            push_rst(c, 0);
            push_rst(c, 7);
        end
        // Full instance: CLK_DIV=2, pixel index = n/2.
        push(4, 0, 0); push(4, 6, 1); push(4, 4, 1); push(4, 5, 1); push(4, 2, 1); push(4, 3, 1);
        push(5, 0, 1); push(5, 5, 0); push(5, 6, 0);
        push(6, 0, 1); push(6, 5, 1);
        push(7, 0, 2); push(7, 5, 0);
        push(1282, 0, 639); push(1282, 4, 1);
        push(1283, 0, 640); push(1283, 4, 0);
        push(1314, 0, 655); push(1314, 2, 1);
        push(1315, 0, 656); push(1315, 2, 0);
        push(1506, 0, 751); push(1506, 2, 0);
        push(1507, 0, 752); push(1507, 2, 1);
        push(1602, 0, 799); push(1602, 1, 0);
        push(1603, 0, 0); push(1603, 1, 1); push(1603, 4, 1); push(1603, 6, 0);
        push(3203, 0, 0); push(3203, 1, 2);
        // Small instance: CLK_DIV=3, 16 px/line, 12 lines, hsync low H 10..12, vsync low V 8..9.
        push(4, 13, 1); push(4, 11, 1); push(4, 12, 0); push(4, 7, 0);
        push(5, 12, 1); push(5, 13, 0); push(5, 7, 0);
        push(6, 7, 1); push(6, 12, 0);
        push(32, 7, 9); push(32, 9, 1);
        push(33, 7, 10); push(33, 9, 0);
        push(41, 7, 12); push(41, 9, 0);
        push(42, 7, 13); push(42, 9, 1);
        push(243, 7, 0); push(243, 8, 5); push(243, 11, 1);
        push(291, 7, 0); push(291, 8, 6); push(291, 11, 0);
        push(386, 8, 7); push(386, 10, 1);
        push(387, 8, 8); push(387, 10, 0); push(387, 7, 0);
        push(482, 8, 9); push(482, 10, 0);
        push(483, 8, 10); push(483, 10, 1);
        push(578, 7, 15); push(578, 8, 11); push(578, 13, 0);
        push(579, 7, 0); push(579, 8, 0); push(579, 13, 1); push(579, 11, 1); push(579, 10, 1);
        push(580, 13, 0);
        // Mid-frame reset of the small instance at (5,3) of the second frame.
        push(738, 7, 5); push(738, 8, 3);
        push_rst(739, 7);
        push(740, 7, 0); push(740, 8, 0); push(740, 13, 1); push(740, 11, 1); push(740, 12, 0);
        push(741, 12, 1); push(741, 13, 0);
        push(742, 7, 1);
`ifdef VGA_RGB_BLANK_EN
        push(2, 14, 0); push(4, 14, 5); push(1283, 14, 0);
        push(2, 15, 0); push(105, 15, 5); push(135, 15, 0); push(345, 15, 0);
`endif

        do begin @(posedge clk); #1; end while (t < 3);
        rst_f_n = 1'b1;
        rst_s_n = 1'b1;
        do begin @(posedge clk); #1; end while (t < 4);
        n_checks++;
        if (fs_f !== 1'b1) begin
            n_errors++;
            $display("FAIL f_frame_start at reset exit: got %b", fs_f);
        end
        n_checks++;
        if (vo_f !== 1'b1) begin
            n_errors++;
            $display("FAIL f_video_on at reset exit: got %b", vo_f);
        end
        n_checks++;
        if (hc_f !== 10'd0) begin
            n_errors++;
            $display("FAIL f_hcount at reset exit: got %0d", hc_f);
        end
        n_checks++;
        if (pt_f !== 1'b1) begin
            n_errors++;
            $display("FAIL f_pixel_tick at reset exit: got %b", pt_f);
        end
        n_checks++;
        if (fs_s !== 1'b1) begin
            n_errors++;
            $display("FAIL s_frame_start at reset exit: got %b", fs_s);
        end
        do begin @(posedge clk); #1; end while (t < 738);
        rst_s_n = 1'b0;
        @(posedge clk); #1;
        rst_s_n = 1'b1;
        do begin @(posedge clk); #1; end while (t < 3210);

        while (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s @cyc %0d: got no sample, expected %0d",
                     nm[sb[0].sig], sb[0].cyc, sb[0].exp);
            sb.delete(0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
